retro_line_fetch_stall: RTL

- Upstream companion to the CATC timing controller.
- Serves core read requests from a single-line fetch buffer.
- On a miss, it raises Stall so CATC stops issuing clock enables and accrues catch-up. It then burst-fetches the line from external (load-image) memory over a valid/ready request and valid-only response channel.
- Used by cartless/load-image cores where one fetch costs several microseconds.

---
 rtl/retro_line_fetch_stall_if.sv | 11 +
 rtl/retro_line_fetch_stall.sv | 128 ++++++++++++
 2 files changed

// File: rtl/retro_line_fetch_stall_if.sv
// System connection bundle: single clock plus
// synchronous active-high reset.
interface ISysCon;
  logic CLK;
  logic RST;

  modport slave (
    input CLK,
    input RST
  );
endinterface

// File: rtl/retro_line_fetch_stall.sv
// Single-line fetch buffer: serves core reads on a hit, stalls
// and burst-fills the line from external memory on a miss.
module retro_line_fetch_stall #(
  parameter int AddrWidth     = 16,
  parameter int DataWidth     = 8,
  parameter int LineBytes     = 16,
  parameter int MissCountBits = 16
) (
  ISysCon.slave                   SysCon,
  input  logic                    CoreReq,
  input  logic [AddrWidth-1:0]    CoreAddr,
  input  logic                    CoreCE,
  output logic [DataWidth-1:0]    CoreRData,
  output logic                    Stall,
  input  logic                    Invalidate,
  output logic                    MemReqValid,
  input  logic                    MemReqReady,
  output logic [AddrWidth-1:0]    MemReqAddr,
  input  logic                    MemRspValid,
  input  logic [DataWidth-1:0]    MemRspData,
  output logic [MissCountBits-1:0] MissCount
);

  localparam int OffW = $clog2(LineBytes);
  localparam int TagW = AddrWidth - OffW;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;

  logic [1:0]               state_q, state_d;
  logic                     lv_q, lv_d;
  logic [TagW-1:0]          tag_q, tag_d;
  logic [TagW-1:0]          ftag_q, ftag_d;
  logic [OffW-1:0]          beat_q, beat_d;
  logic                     disc_q, disc_d;
  logic [MissCountBits-1:0] miss_q, miss_d;
  logic [DataWidth-1:0]     buf_q [LineBytes];

  logic [TagW-1:0] core_tag;
  logic            hit;
  logic            last_beat;
  logic            ce_unused;

  // CE is only the core's acceptance qualifier; nothing here needs it.
  assign ce_unused = CoreCE;

  assign core_tag  = CoreAddr[AddrWidth-1:OffW];
  assign hit       = lv_q && (state_q == IDLE) && (tag_q == core_tag);
  assign last_beat = (beat_q == OffW'(LineBytes - 1));

  assign Stall       = (CoreReq && !hit) || (state_q != IDLE);
  assign CoreRData   = buf_q[CoreAddr[OffW-1:0]];
  assign MemReqValid = (state_q == ISSUE);
  assign MemReqAddr  = {ftag_q, {OffW{1'b0}}};
  assign MissCount   = miss_q;

  // Next-state: miss detection, request issue and line fill.
  always_comb begin
    state_d = state_q;
    lv_d    = lv_q;
    tag_d   = tag_q;
    ftag_d  = ftag_q;
    beat_d  = beat_q;
    disc_d  = disc_q;
    miss_d  = miss_q;
    unique case (state_q)
      IDLE: begin
        if (Invalidate) lv_d = 1'b0;
        if (CoreReq && !hit) begin
          ftag_d  = core_tag;
          lv_d    = 1'b0;
          state_d = ISSUE;
          if (miss_q != {MissCountBits{1'b1}})
            miss_d = miss_q + 1'b1;
        end
      end
      ISSUE: begin
        if (Invalidate) disc_d = 1'b1;
        if (MemReqReady) begin
          beat_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (Invalidate) disc_d = 1'b1;
        if (MemRspValid) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            tag_d   = ftag_q;
            lv_d    = !disc_q && !Invalidate;
            disc_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge SysCon.CLK) begin
    if (SysCon.RST) begin
      state_q <= IDLE;
      lv_q    <= 1'b0;
      tag_q   <= '0;
      ftag_q  <= '0;
      beat_q  <= '0;
      disc_q  <= 1'b0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      lv_q    <= lv_d;
      tag_q   <= tag_d;
      ftag_q  <= ftag_d;
      beat_q  <= beat_d;
      disc_q  <= disc_d;
      miss_q  <= miss_d;
    end
  end

  // Line storage: written beat by beat during fill, never reset.
  always_ff @(posedge SysCon.CLK) begin
    if (!SysCon.RST && (state_q == FILL) && MemRspValid)
      buf_q[beat_q] <= MemRspData;
  end

endmodule
